counter_ctrl: RTL and testbench

COUNTER_CTRL -- requirements
Module: counter_ctrl

---
 rtl/counter_ctrl_if.sv | 29 ++
 rtl/counter_ctrl.sv | 173 +++++++++++++++++
 tb/tb_counter_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/counter_ctrl_if.sv
// Bundles the run-request handshake, the run configuration, the controlled
// counter's value/reset pair and the status outputs of counter_ctrl.
// The slave modport is the controller side; the master modport is the
// side that issues runs and owns the controlled counter.
interface counter_ctrl_if #(
  parameter int Size = 5
);
  logic            start_valid;
  logic            start_ready;
  logic [Size-1:0] limit;
  logic            periodic;
  logic            stop;
  logic [Size-1:0] count;
  logic            counter_reset;
  logic            busy;
  logic            done;
  logic [7:0]      periods;
  logic            error;

  modport slave (
    input  start_valid, limit, periodic, stop, count,
    output start_ready, counter_reset, busy, done, periods, error
  );

  modport master (
    output start_valid, limit, periodic, stop, count,
    input  start_ready, counter_reset, busy, done, periods, error
  );
endinterface

// File: rtl/counter_ctrl.sv
// counter_ctrl: supervises an external up-counter. A run is launched through
// a valid/ready handshake that captures the terminal count and the mode
// (one-shot or auto-reload). While in RUN the external counter is released
// from reset; when it reaches the captured limit a one-cycle done pulse is
// issued and the period count advances. All outputs are registered.
//
// Optional feature: define COUNTER_CTRL_TIMEOUT_EN to build a RUN-cycle
// watchdog that aborts a run whose counter skips past the limit and raises
// a sticky error flag. Without it, error is tied to 0.
module counter_ctrl #(
  parameter int Size = 5
) (
  input  logic             i_clock,
  input  logic             i_reset,
  counter_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_RELOAD = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [Size-1:0] r_limit;
  logic            r_periodic;
  logic            r_start_ready;
  logic            r_counter_reset;
  logic            r_busy;
  logic            r_done;
  logic [7:0]      r_periods;
  logic            r_error;

  logic            w_match;
  logic            w_accept;
  logic            w_period_end;
  logic            w_timeout;

  // Output encoding of a state: {start_ready, counter_reset, busy}.
  function automatic logic [2:0] f_outputs(input state_t s);
    case (s)
      ST_IDLE:   return 3'b110;
      ST_RUN:    return 3'b001;
      ST_RELOAD: return 3'b011;
      ST_DONE:   return 3'b011;
      default:   return 3'b110;
    endcase
  endfunction

  assign w_match      = (bus.count == r_limit);
  // A start coinciding with stop is discarded.
  assign w_accept     = (r_state == ST_IDLE) && bus.start_valid && r_start_ready && !bus.stop;
  // stop beats a simultaneous match: no pulse, no period increment.
  assign w_period_end = (r_state == ST_RUN) && !bus.stop && w_match;

`ifdef COUNTER_CTRL_TIMEOUT_EN
  // The watchdog value 2^Size is only reachable when the counter ran past
  // the limit: a legal period lasts at most 2^Size RUN cycles.
  localparam logic [Size:0] WDOG_LAST = {1'b1, {Size{1'b0}}};

  logic [Size:0] r_wdog;

  assign w_timeout = (r_state == ST_RUN) && !bus.stop && !w_match && (r_wdog == WDOG_LAST);

  // Watchdog: cleared on every entry into RUN, counts cycles spent in RUN.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wdog <= '0;
    end else if ((w_next_state == ST_RUN) && (r_state != ST_RUN)) begin
      r_wdog <= '0;
    end else if (r_state == ST_RUN) begin
      r_wdog <= r_wdog + {{Size{1'b0}}, 1'b1};
    end else begin
      r_wdog <= r_wdog;
    end
  end

  // Sticky error: set by a watchdog expiry, cleared by the next accepted start.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_error <= 1'b0;
    end else if (w_accept) begin
      r_error <= 1'b0;
    end else if (w_timeout) begin
      r_error <= 1'b1;
    end else begin
      r_error <= r_error;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign r_error   = 1'b0;
`endif

  // Next-state decision; stop in any busy state returns to IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = ST_RUN;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          w_next_state = ST_IDLE;
        end else if (w_match) begin
          w_next_state = r_periodic ? ST_RELOAD : ST_DONE;
        end else if (w_timeout) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_RELOAD: begin
        if (bus.stop) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // FSM state, run configuration and registered status outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state         <= ST_IDLE;
      r_start_ready   <= 1'b1;
      r_counter_reset <= 1'b1;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_periods       <= 8'd0;
      r_limit         <= '0;
      r_periodic      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      {r_start_ready, r_counter_reset, r_busy} <= f_outputs(w_next_state);
      r_done  <= w_period_end;
      if (w_accept) begin
        r_limit    <= bus.limit;
        r_periodic <= bus.periodic;
        r_periods  <= 8'd0;
      end else if (w_period_end) begin
        r_limit    <= r_limit;
        r_periodic <= r_periodic;
        r_periods  <= r_periods + 8'd1;
      end else begin
        r_limit    <= r_limit;
        r_periodic <= r_periodic;
        r_periods  <= r_periods;
      end
    end
  end

  assign bus.start_ready   = r_start_ready;
  assign bus.counter_reset = r_counter_reset;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.periods       = r_periods;
  assign bus.error         = r_error;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed testbench for counter_ctrl. A small model of the controlled
// counter (cleared while counter_reset is high, otherwise incrementing, with
// an optional skip of value 31) feeds count back to the controller.
module tb_counter_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic skip31;
  int   n_done;

  counter_ctrl_if #(.Size(5)) bus ();

  counter_ctrl #(.Size(5)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controlled counter model.
  always @(posedge clk) begin
    if (rst || bus.counter_reset) begin
      bus.count <= 5'd0;
    end else if (skip31 && (bus.count == 5'd30)) begin
      bus.count <= 5'd0;
    end else begin
      bus.count <= bus.count + 5'd1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic [7:0] exp_periods);
    chk({tag, "_ready"}, {31'd0, bus.start_ready}, 32'd1);
    chk({tag, "_creset"}, {31'd0, bus.counter_reset}, 32'd1);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_periods"}, {24'd0, bus.periods}, {24'd0, exp_periods});
  endtask

  initial begin
    n_checks         = 0;
    n_errors         = 0;
    skip31           = 1'b0;
    rst              = 1'b1;
    bus.start_valid  = 1'b0;
    bus.limit        = 5'd0;
    bus.periodic     = 1'b0;
    bus.stop         = 1'b0;
    bus.count        = 5'd0;

    // Reset state.
    tick();
    tick();
    rst = 1'b0;
    chk_idle("reset", 8'd0);
    chk("reset_error", {31'd0, bus.error}, 32'd0);

    // One-shot, limit 3: start at cycle 0, RUN 1-4, DONE 5, IDLE 6.
    bus.start_valid = 1'b1; bus.limit = 5'd3; bus.periodic = 1'b0;
    tick();                                            // cycle 1
    chk("os_c1_busy", {31'd0, bus.busy}, 32'd1);
    chk("os_c1_creset", {31'd0, bus.counter_reset}, 32'd0);
    chk("os_c1_ready", {31'd0, bus.start_ready}, 32'd0);
    // Later changes to limit/periodic and stray starts must be ignored.
    bus.limit = 5'd9; bus.periodic = 1'b1;
    tick(); tick(); tick();                            // cycle 4
    bus.start_valid = 1'b0;
    chk("os_c4_count", {27'd0, bus.count}, 32'd3);
    chk("os_c4_done", {31'd0, bus.done}, 32'd0);
    tick();                                            // cycle 5
    chk("os_c5_done", {31'd0, bus.done}, 32'd1);
    chk("os_c5_busy", {31'd0, bus.busy}, 32'd1);
    chk("os_c5_creset", {31'd0, bus.counter_reset}, 32'd1);
    chk("os_c5_periods", {24'd0, bus.periods}, 32'd1);
    tick();                                            // cycle 6
    chk_idle("os_c6", 8'd1);

    // Periodic, limit 2: done every 4 cycles, 5 periods in 20 cycles.
    bus.start_valid = 1'b1; bus.limit = 5'd2; bus.periodic = 1'b1;
    n_done = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      bus.start_valid = 1'b0;
      if (bus.done === 1'b1) n_done++;
      chk($sformatf("per_done_c%0d", k), {31'd0, bus.done}, {31'd0, (k % 4) == 0});
      chk($sformatf("per_creset_c%0d", k), {31'd0, bus.counter_reset}, {31'd0, (k % 4) == 0});
    end
    chk("per_ndone", n_done, 32'd5);
    chk("per_periods", {24'd0, bus.periods}, 32'd5);
    bus.stop = 1'b1;                                   // cycle 21 is RUN
    tick();
    bus.stop = 1'b0;
    chk_idle("per_stop", 8'd5);

    // Limit 0, periodic: done every other cycle.
    bus.start_valid = 1'b1; bus.limit = 5'd0; bus.periodic = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      bus.start_valid = 1'b0;
      chk($sformatf("l0_done_c%0d", k), {31'd0, bus.done}, {31'd0, (k % 2) == 0});
      chk($sformatf("l0_periods_c%0d", k), {24'd0, bus.periods}, k / 2);
    end
    bus.stop = 1'b1;                                   // stop during RELOAD
    tick();
    bus.stop = 1'b0;
    chk_idle("l0_stop", 8'd4);

    // Start together with stop in IDLE is discarded.
    bus.start_valid = 1'b1; bus.stop = 1'b1; bus.limit = 5'd4; bus.periodic = 1'b0;
    tick();
    bus.stop = 1'b0;
    chk_idle("startstop", 8'd4);

    // Abort: stop in the cycle count == limit (limit 4 -> cycle 5).
    tick();                                            // accepted, cycle 1
    bus.start_valid = 1'b0;
    tick(); tick(); tick(); tick();                    // cycle 5
    chk("ab_count", {27'd0, bus.count}, 32'd4);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk_idle("ab", 8'd0);
    tick();
    chk("ab_nodone", {31'd0, bus.done}, 32'd0);

    // Reset mid-run at count 7 (also a match for limit 7, reset wins).
    bus.start_valid = 1'b1; bus.limit = 5'd7; bus.periodic = 1'b1;
    tick();
    bus.start_valid = 1'b0;
    for (int k = 2; k <= 17; k++) tick();              // cycle 17
    chk("rm_count", {27'd0, bus.count}, 32'd7);
    chk("rm_periods_before", {24'd0, bus.periods}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("rm", 8'd0);
    tick();
    chk("rm_nodone", {31'd0, bus.done}, 32'd0);

    // Counter skipping the limit (31).
    skip31 = 1'b1;
    bus.start_valid = 1'b1; bus.limit = 5'd31; bus.periodic = 1'b0;
    tick();                                            // cycle 1
    bus.start_valid = 1'b0;
    for (int k = 2; k <= 33; k++) tick();              // cycle 33
    chk("to_c33_busy", {31'd0, bus.busy}, 32'd1);
    chk("to_c33_error", {31'd0, bus.error}, 32'd0);
    tick();                                            // cycle 34
`ifdef COUNTER_CTRL_TIMEOUT_EN
    chk("to_error", {31'd0, bus.error}, 32'd1);
    chk_idle("to", 8'd0);
    skip31 = 1'b0;
    bus.start_valid = 1'b1; bus.limit = 5'd2;
    tick();
    bus.start_valid = 1'b0;
    chk("to_error_cleared", {31'd0, bus.error}, 32'd0);
    chk("to_restart_busy", {31'd0, bus.busy}, 32'd1);
`else
    chk("to_error_tied", {31'd0, bus.error}, 32'd0);
    chk("to_still_busy", {31'd0, bus.busy}, 32'd1);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    skip31 = 1'b0;
    chk_idle("to_stop", 8'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
